// File: rtl/intm_iter_fu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : intm_iter_fu_pkg
//  Purpose  : Shared uop types for the integer multiply/divide unit:
//             RV32M funct3 encodings, the issued-uop record from the
//             reservation station, and the result finalisation helper.
//  Revision : 1.0 - initial release
// ============================================================================
package intm_iter_fu_pkg;

    localparam int MD_DATA_W = 32;
    localparam int ROB_ID_W  = 5;
    localparam int PHY_W     = 6;
    localparam int ARCH_W    = 5;

    // fu_opcode carries funct3 of the RV32M instruction unchanged
    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } md_op_t;

    typedef struct packed {
        logic [ROB_ID_W-1:0]  rob_id;
        logic [PHY_W-1:0]     rd_phy;
        logic [ARCH_W-1:0]    rd_arch;
        logic [2:0]           fu_opcode;
        logic [MD_DATA_W-1:0] rs1_value;
        logic [MD_DATA_W-1:0] rs2_value;
    } intm_rs_reg_t;

    // Turns a magnitude-domain accumulator into the architectural result.
    // For multiplies acc is the unsigned 64-bit product {hi,lo}; for
    // divides acc is {remainder, quotient}.
    function automatic logic [MD_DATA_W-1:0] md_finalize(
        input md_op_t                 op,
        input logic                   neg_res,
        input logic                   neg_rem,
        input logic [2*MD_DATA_W-1:0] acc
    );
        logic [2*MD_DATA_W-1:0] prod;
        logic [MD_DATA_W-1:0]   quo;
        logic [MD_DATA_W-1:0]   rem;
        prod = neg_res ? -acc : acc;
        quo  = neg_res ? -acc[MD_DATA_W-1:0] : acc[MD_DATA_W-1:0];
        rem  = neg_rem ? -acc[2*MD_DATA_W-1:MD_DATA_W] : acc[2*MD_DATA_W-1:MD_DATA_W];
        case (op)
            MD_MUL:                        md_finalize = prod[MD_DATA_W-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU:  md_finalize = prod[2*MD_DATA_W-1:MD_DATA_W];
            MD_DIV, MD_DIVU:               md_finalize = quo;
            default:                       md_finalize = rem;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/cdb_itf.sv
`default_nettype none
// ============================================================================
//  Module   : cdb_itf
//  Purpose  : Common data bus port of one functional unit. The unit drives
//             the fu modport; the broadcast/arbiter side uses the rs modport.
//  Revision : 1.0 - initial release
// ============================================================================
interface cdb_itf;
    logic                                   valid;
    logic [intm_iter_fu_pkg::ROB_ID_W-1:0]  rob_id;
    logic [intm_iter_fu_pkg::PHY_W-1:0]     rd_phy;
    logic [intm_iter_fu_pkg::ARCH_W-1:0]    rd_arch;
    logic [intm_iter_fu_pkg::MD_DATA_W-1:0] rd_value;

    modport fu (output valid, rob_id, rd_phy, rd_arch, rd_value);
    modport rs (input  valid, rob_id, rd_phy, rd_arch, rd_value);
endinterface
`default_nettype wire

// File: rtl/intm_iter_fu_shift_core.sv
`default_nettype none
// ============================================================================
//  Module   : intm_shift_core
//  Purpose  : Shared radix-2 datapath for unsigned magnitudes. One step per
//             cycle: shift-add multiply or restoring divide on a 2W-bit
//             accumulator, with a 5-bit step counter. done is high during
//             the final step, and acc_nxt then holds the finished value.
//  Revision : 1.0 - initial release
// ============================================================================
module intm_shift_core #(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           step,
    input  logic           op_is_div,
    input  logic [W-1:0]   opa,
    input  logic [W-1:0]   opb,
    output logic           done,
    output logic [2*W-1:0] acc_nxt
);

    logic [2*W-1:0] acc;
    logic [W-1:0]   opb_q;
    logic           div_q;
    logic [4:0]     count;

    logic [W:0]     mul_sum;
    logic [W:0]     div_trial;
    logic [W:0]     div_diff;

    // One iteration of the selected algorithm on the current accumulator
    always_comb begin
        // multiply: acc = {partial, multiplier}; add when the LSB is set, shift right
        mul_sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opb_q} : {(W+1){1'b0}});
        // divide: acc = {remainder, dividend/quotient}; shift left, trial subtract
        div_trial = acc[2*W-1:W-1];
        div_diff  = div_trial - {1'b0, opb_q};
        if (div_q) begin
            if (!div_diff[W]) acc_nxt = {div_diff[W-1:0], acc[W-2:0], 1'b1};
            else              acc_nxt = {div_trial[W-1:0], acc[W-2:0], 1'b0};
        end else begin
            acc_nxt = {mul_sum, acc[W-1:1]};
        end
    end

    assign done = step && (count == 5'd31);

    // Load operands on start, otherwise advance one step while enabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            opb_q <= '0;
            div_q <= 1'b0;
            count <= 5'd0;
        end else if (start) begin
            acc   <= {{W{1'b0}}, opa};
            opb_q <= opb;
            div_q <= op_is_div;
            count <= 5'd0;
        end else if (step) begin
            acc   <= acc_nxt;
            count <= count + 5'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/intm_iter_fu.sv
`default_nettype none
// ============================================================================
//  Module   : intm_iter_fu
//  Purpose  : Iterative RV32M multiply/divide unit. Accepts one uop per
//             handshake, runs 32 shift/subtract steps on magnitudes, applies
//             sign correction and holds a single result on its CDB port.
//             Divide-by-zero and signed overflow finish at accept.
//  Config   : INTM_FAST_MUL_EN - MUL* use a combinational product and
//             finish at accept; DIV* unchanged.
//  Revision : 1.0 - initial release
// ============================================================================
module intm_iter_fu
    import intm_iter_fu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         prv_valid,
    output logic         prv_ready,
    input  intm_rs_reg_t intm_rs_in,
    output logic         nxt_valid,
    input  logic         nxt_ready,
    cdb_itf.fu           cdb
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    // incoming uop decode
    md_op_t            in_op;
    logic [DATA_W-1:0] rs1, rs2;
    logic              in_is_div;
    logic              in_a_signed, in_b_signed;
    logic              in_neg_a, in_neg_b;
    logic [DATA_W-1:0] abs_a, abs_b;
    logic              div_by_zero, div_ovf;
    logic              special;
    logic [DATA_W-1:0] special_value;

    // control
    logic              accept;
    logic              core_start;
    logic              core_done;
    logic [2*DATA_W-1:0] core_acc_nxt;

    // held op context and CDB registers
    md_op_t              op_q;
    logic                neg_res_q, neg_rem_q;
    logic [ROB_ID_W-1:0] rob_id_q;
    logic [PHY_W-1:0]    rd_phy_q;
    logic [ARCH_W-1:0]   rd_arch_q;
    logic [DATA_W-1:0]   rd_value_q;

    assign in_op     = md_op_t'(intm_rs_in.fu_opcode);
    assign rs1       = intm_rs_in.rs1_value;
    assign rs2       = intm_rs_in.rs2_value;
    assign in_is_div = in_op[2];

    assign in_a_signed = (in_op == MD_MUL) || (in_op == MD_MULH) || (in_op == MD_MULHSU) ||
                         (in_op == MD_DIV) || (in_op == MD_REM);
    assign in_b_signed = (in_op == MD_MUL) || (in_op == MD_MULH) ||
                         (in_op == MD_DIV) || (in_op == MD_REM);
    assign in_neg_a    = in_a_signed && rs1[DATA_W-1];
    assign in_neg_b    = in_b_signed && rs2[DATA_W-1];
    // 0x80000000 negates to itself, which is still the right unsigned magnitude
    assign abs_a       = in_neg_a ? -rs1 : rs1;
    assign abs_b       = in_neg_b ? -rs2 : rs2;

    assign div_by_zero = in_is_div && (rs2 == '0);
    assign div_ovf     = ((in_op == MD_DIV) || (in_op == MD_REM)) &&
                         (rs1 == {1'b1, {(DATA_W-1){1'b0}}}) && (rs2 == '1);

`ifdef INTM_FAST_MUL_EN
    logic [2*DATA_W-1:0] fast_prod;
    assign fast_prod = {{DATA_W{1'b0}}, abs_a} * {{DATA_W{1'b0}}, abs_b};
`endif

    // Cases resolved at accept time, without entering BUSY
    always_comb begin
        special       = 1'b0;
        special_value = '0;
        if (div_by_zero) begin
            special       = 1'b1;
            special_value = ((in_op == MD_DIV) || (in_op == MD_DIVU)) ? '1 : rs1;
        end else if (div_ovf) begin
            special       = 1'b1;
            special_value = (in_op == MD_DIV) ? {1'b1, {(DATA_W-1){1'b0}}} : '0;
        end
`ifdef INTM_FAST_MUL_EN
        else if (!in_is_div) begin
            special       = 1'b1;
            special_value = md_finalize(in_op, in_neg_a ^ in_neg_b, in_neg_a, fast_prod);
        end
`endif
    end

    intm_shift_core #(
        .W (DATA_W)
    ) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (core_start),
        .step      (state == ST_BUSY),
        .op_is_div (in_is_div),
        .opa       (abs_a),
        .opb       (abs_b),
        .done      (core_done),
        .acc_nxt   (core_acc_nxt)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next state, handshake and core launch
    always_comb begin
        state_nxt  = state;
        prv_ready  = !flush && ((state == ST_IDLE) || ((state == ST_DONE) && nxt_ready));
        accept     = prv_valid && prv_ready;
        core_start = accept && !special;
        if (flush) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (accept)    state_nxt = special ? ST_DONE : ST_BUSY;
                ST_BUSY: if (core_done) state_nxt = ST_DONE;
                ST_DONE: if (nxt_ready) state_nxt = accept ? (special ? ST_DONE : ST_BUSY) : ST_IDLE;
                default:                state_nxt = ST_IDLE;
            endcase
        end
    end

    // Capture uop context at accept, result at special accept or last step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= MD_MUL;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            rob_id_q   <= '0;
            rd_phy_q   <= '0;
            rd_arch_q  <= '0;
            rd_value_q <= '0;
        end else if (accept) begin
            op_q      <= in_op;
            neg_res_q <= in_neg_a ^ in_neg_b;
            neg_rem_q <= in_neg_a;
            rob_id_q  <= intm_rs_in.rob_id;
            rd_phy_q  <= intm_rs_in.rd_phy;
            rd_arch_q <= intm_rs_in.rd_arch;
            if (special) rd_value_q <= special_value;
        end else if ((state == ST_BUSY) && core_done && !flush) begin
            rd_value_q <= md_finalize(op_q, neg_res_q, neg_rem_q, core_acc_nxt);
        end
    end

    assign nxt_valid    = (state == ST_DONE);
    assign cdb.valid    = nxt_valid;
    assign cdb.rob_id   = rob_id_q;
    assign cdb.rd_phy   = rd_phy_q;
    assign cdb.rd_arch  = rd_arch_q;
    assign cdb.rd_value = rd_value_q;

endmodule
`default_nettype wire
